aes_round_sequencer: RTL and testbench

//  Iterative AES-128 encryption controller. Accepts one 128-bit block, applies the initial AddRoundKey, then runs NR rounds at one round per clock.

---
 rtl/aes_round_sequencer.sv | 125 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Purpose:
//   Iterative AES-128 encryption controller. One plaintext block is accepted,
//   the initial AddRoundKey is applied on the way in, and then NR rounds run at
//   one round per clock. The SubBytes/ShiftRows/MixColumns work is done by an
//   external combinational round function. This block adds the round-key XOR
//   to each result. The ciphertext leaves on a valid/ready stream.
//
// Parameters:
//   NR         number of cipher rounds; round-key indices 0..NR are used
//   KIDX_W     width of key_idx; 2**KIDX_W must exceed NR
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   plaintext block valid
//   in_ready   out  block can be accepted (only while idle)
//   in_block   in   128-bit plaintext
//   key_idx    out  round-key index requested from the key store
//   round_key  in   subkey for key_idx, same cycle
//   rf_in      out  state presented to the round function
//   rf_final   out  final round; round function skips MixColumns
//   rf_out     in   round-function result, same cycle
//   out_valid  out  ciphertext valid
//   out_ready  in   downstream accepts ciphertext
//   out_block  out  128-bit ciphertext
//   busy       out  a block is being processed or is waiting to leave
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_block,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic [127:0]      rf_in,
    output logic              rf_final,
    input  logic [127:0]      rf_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_block,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    localparam logic [KIDX_W-1:0] LAST_ROUND = KIDX_W'(NR);

    fsm_e              fsm_q, fsm_d;
    logic [KIDX_W-1:0] round_cnt_q, round_cnt_d;
    logic [127:0]      state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            round_cnt_q <= '0;
            state_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_cnt_q <= round_cnt_d;
            state_q     <= state_d;
        end
    end

    // While idle, key_idx is 0, so round_key is the whitening key. This lets
    // the initial AddRoundKey happen on the accept edge.
    // The round counter stops at NR. The DONE handshake clears it back to 0.
    always_comb begin
        fsm_d       = fsm_q;
        round_cnt_d = round_cnt_q;
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        key_idx     = '0;
        rf_final    = 1'b0;
        rf_in       = state_q;
        out_block   = state_q;

        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d     = in_block ^ round_key;
                    round_cnt_d = KIDX_W'(1);
                    fsm_d       = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                key_idx  = round_cnt_q;
                rf_final = (round_cnt_q == LAST_ROUND);
                state_d  = rf_out ^ round_key;
                if (round_cnt_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    round_cnt_d = round_cnt_q + KIDX_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d       = IDLE;
                    round_cnt_d = '0;
                end
            end
            default: begin
                fsm_d       = IDLE;
                round_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Bench for aes_round_sequencer. A reference key store (FIPS-197 key
// expansion) and a reference round function (SubBytes/ShiftRows/MixColumns)
// sit behind key_idx/round_key and rf_in/rf_final/rf_out. The expected
// ciphertexts are the published FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [127:0] inBlock;
    logic [3:0]   keyIdx;
    logic [127:0] roundKey;
    logic [127:0] rfIn;
    logic         rfFinal;
    logic [127:0] rfOut;
    logic         outValid;
    logic         outReady;
    logic [127:0] outBlock;
    logic         busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]   sboxTab [0:255];
    logic [127:0] rkTab   [0:15];

    aes_round_sequencer #(.NR(10), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_block  (inBlock),
        .key_idx   (keyIdx),
        .round_key (roundKey),
        .rf_in     (rfIn),
        .rf_final  (rfFinal),
        .rf_out    (rfOut),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_block (outBlock),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) helpers for the reference AES model.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // The S-box is the multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] computeSbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] x, input logic fin);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = sboxTab[x[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (fin) begin
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                r[127-32*c -: 32] = {
                    xtime(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ gmul(a2, 8'h03) ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ gmul(a3, 8'h03),
                    gmul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return r;
    endfunction

    always_comb roundKey = rkTab[keyIdx];
    always_comb rfOut = aesRound(rfIn, rfFinal);

    task automatic setKey(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp  = subWord({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) rkTab[k] = '0;
        for (int k = 0; k < 11; k++) rkTab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // Present a block at a falling edge. The DUT takes it on the next rising
    // edge. Return at the falling edge after the accept.
    task automatic applyStimulus(input logic [127:0] pt);
        @(negedge clk);
        checkOutput("in_ready_before_accept", inReady, 1);
        inBlock = pt;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
    endtask

    // Count edges from the accept to out_valid, and check the key index of every round.
    task automatic waitOutput(output int lat);
        lat = 0;
        while (!outValid && lat < 30) begin
            checkOutput("key_idx_round", keyIdx, lat + 1);
            checkOutput("rf_final_round", rfFinal, (lat == 9));
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finishHandshake();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("out_valid_after_handshake", outValid, 0);
        checkOutput("in_ready_after_handshake", inReady, 1);
        checkOutput("key_idx_idle", keyIdx, 0);
    endtask

    initial begin
        int lat;
        int accepts [$];
        int nextIdx;
        int n;

        for (int i = 0; i < 256; i++) sboxTab[i] = computeSbox(8'(i));
        setKey(KEY_B);
        rstN     = 1'b0;
        inValid  = 1'b0;
        inBlock  = '0;
        outReady = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_key_idx", keyIdx, 0);
        checkOutput("rst_rf_final", rfFinal, 0);
        checkOutput("rst_out_block", outBlock, 0);
        @(negedge clk);
        rstN = 1'b1;

        // FIPS-197 Appendix B vector, with the latency check
        $display("[TB] FIPS-197 App.B vector");
        applyStimulus(PT_B);
        waitOutput(lat);
        checkOutput("latency_b", lat, 10);
        checkOutput("ct_b", outBlock, CT_B);
        checkOutput("busy_done", busy, 1);
        checkOutput("in_ready_done", inReady, 0);
        checkOutput("key_idx_done", keyIdx, 0);
        checkOutput("rf_final_done", rfFinal, 0);
        finishHandshake();

        // App.C.1 vector, then hold out_ready low while in_valid pulses
        $display("[TB] FIPS-197 App.C.1 vector with output stall");
        setKey(KEY_C);
        applyStimulus(PT_C);
        waitOutput(lat);
        checkOutput("latency_c", lat, 10);
        for (int i = 0; i < 20; i++) begin
            checkOutput("stall_out_valid", outValid, 1);
            checkOutput("stall_out_block", outBlock, CT_C);
            checkOutput("stall_in_ready", inReady, 0);
            inValid = i[0];
            inBlock = PT_B;
            @(negedge clk);
        end

        // With in_valid and out_ready high together, only the output handshake completes.
        inBlock  = PT_C;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("simul_in_ready", inReady, 1);
        checkOutput("simul_busy", busy, 0);
        checkOutput("simul_out_valid", outValid, 0);

        // Back-to-back blocks with both handshakes held high
        $display("[TB] back-to-back blocks");
        nextIdx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (inReady) begin
                accepts.push_back(cyc);
                checkOutput("b2b_key_idx_idle", keyIdx, 0);
                nextIdx = 1;
            end else if (outValid) begin
                checkOutput("b2b_ct", outBlock, CT_C);
                checkOutput("b2b_key_idx_done", keyIdx, 0);
            end else begin
                checkOutput("b2b_key_idx", keyIdx, nextIdx);
                checkOutput("b2b_rf_final", rfFinal, (nextIdx == 10));
                nextIdx++;
            end
            @(negedge clk);
        end
        checkOutput("b2b_accept_count", accepts.size(), 4);
        for (int i = 1; i < accepts.size(); i++)
            checkOutput("b2b_spacing", accepts[i] - accepts[i-1], 12);
        inValid = 1'b0;
        n = 0;
        while (!inReady && n < 30) begin
            n++;
            @(negedge clk);
        end
        outReady = 1'b0;
        checkOutput("b2b_drain_idle", inReady, 1);

        // Reset asserted during round 5
        $display("[TB] reset mid-operation");
        setKey(KEY_B);
        applyStimulus(PT_B);
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_key_idx", keyIdx, 5);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", inReady, 1);
        checkOutput("midrst_key_idx", keyIdx, 0);
        checkOutput("midrst_rf_final", rfFinal, 0);
        checkOutput("midrst_out_block", outBlock, 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(PT_B);
        waitOutput(lat);
        checkOutput("latency_after_reset", lat, 10);
        checkOutput("ct_after_reset", outBlock, CT_B);
        finishHandshake();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
